// File: rtl/t03_pb_event_scanner.sv
// t03_pb_event_scanner: synchronise/debounce pushbuttons, raise press/release/repeat events,
// arbitrate them into a small first-word-fall-through FIFO drained over valid/ready.
module t03_pb_event_scanner #(
  parameter int NUM_BTN         = 21,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_DELAY    = 50,
  parameter int REPEAT_RATE     = 10,
  parameter int FIFO_DEPTH      = 8,
  parameter int IDXW            = $clog2(NUM_BTN)
) (
  input  logic                          hz100,
  input  logic                          reset,
  input  logic [NUM_BTN-1:0]            pb,
  input  logic [NUM_BTN-1:0]            repeat_en,
  input  logic                          evt_ready,
  input  logic                          clr_ovf,
  output logic [NUM_BTN-1:0]            btn_level,
  output logic                          evt_valid,
  output logic [IDXW+1:0]               evt_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          ovf
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RW = $clog2(REPEAT_DELAY + REPEAT_RATE + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  logic [NUM_BTN-1:0] r_sync [SYNC_STAGES];
  logic [DW-1:0]      r_dcnt [NUM_BTN];
  logic [RW-1:0]      r_rcnt [NUM_BTN];
  logic [NUM_BTN-1:0] r_lvl, r_lvl_d, r_press, r_rel, r_rep;
  logic [IDXW+1:0]    r_mem [FIFO_DEPTH];
  logic [PW-1:0]      r_wp, r_rp;
  logic [CW-1:0]      r_cnt;
  logic               r_ovf;
  logic [NUM_BTN-1:0] w_s, w_rise, w_fall, w_act, w_fire, w_hot, w_clr_p, w_clr_r, w_clr_t;
  logic [IDXW-1:0]    w_sel;
  logic [1:0]         w_kind;
  logic               w_hit, w_push, w_pop, w_coal;
  assign w_s    = r_sync[SYNC_STAGES-1];
  assign w_rise = r_lvl & ~r_lvl_d;
  assign w_fall = ~r_lvl & r_lvl_d;
  assign w_act  = r_lvl & repeat_en;
  // Scan high-to-low so the lowest pending channel is the one left selected.
  always_comb begin
    w_fire = '0;
    w_hit  = 1'b0;
    w_sel  = '0;
    w_kind = 2'b00;
    for (int i = NUM_BTN - 1; i >= 0; i--) begin
      w_fire[i] = w_act[i] && (r_rcnt[i] == RW'(REPEAT_DELAY - 1) ||
                               r_rcnt[i] == RW'(REPEAT_DELAY + REPEAT_RATE - 1));
      if (r_press[i] || r_rel[i] || r_rep[i]) begin
        w_hit  = 1'b1;
        w_sel  = IDXW'(i);
        w_kind = r_press[i] ? 2'b01 : r_rel[i] ? 2'b10 : 2'b11;
      end
    end
  end
  assign w_pop   = evt_valid && evt_ready;
  assign w_push  = w_hit && (r_cnt != CW'(FIFO_DEPTH) || evt_ready);
  assign w_hot   = w_push ? NUM_BTN'(1) << w_sel : '0;
  assign w_clr_p = w_kind == 2'b01 ? w_hot : '0;
  assign w_clr_r = w_kind == 2'b10 ? w_hot : '0;
  assign w_clr_t = w_kind == 2'b11 ? w_hot : '0;
  // An event landing on a still-pending bit of the same kind is merged and flagged.
  assign w_coal  = |((r_press & ~w_clr_p & w_rise) | (r_rel & ~w_clr_r & w_fall) |
                     (r_rep & ~w_clr_t & w_fire));
  always_ff @(posedge hz100 or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < SYNC_STAGES; k++) r_sync[k] <= '0;
      for (int i = 0; i < NUM_BTN; i++) begin
        r_dcnt[i] <= '0;
        r_rcnt[i] <= '0;
      end
      r_lvl   <= '0;
      r_lvl_d <= '0;
      r_press <= '0;
      r_rel   <= '0;
      r_rep   <= '0;
      r_ovf   <= 1'b0;
      r_wp    <= '0;
      r_rp    <= '0;
      r_cnt   <= '0;
    end else begin
      r_sync[0] <= pb;
      for (int k = 1; k < SYNC_STAGES; k++) r_sync[k] <= r_sync[k-1];
      for (int i = 0; i < NUM_BTN; i++) begin
        r_dcnt[i] <= (w_s[i] == r_lvl[i] || r_dcnt[i] == DW'(DEBOUNCE_CYCLES - 1)) ? '0 : r_dcnt[i] + 1'b1;
        r_lvl[i]  <= r_lvl[i] ^ (w_s[i] != r_lvl[i] && r_dcnt[i] == DW'(DEBOUNCE_CYCLES - 1));
        r_rcnt[i] <= !w_act[i] ? '0 :
                     r_rcnt[i] == RW'(REPEAT_DELAY + REPEAT_RATE - 1) ? RW'(REPEAT_DELAY) : r_rcnt[i] + 1'b1;
      end
      r_lvl_d <= r_lvl;
      r_press <= (r_press & ~w_clr_p) | w_rise;
      r_rel   <= (r_rel & ~w_clr_r) | w_fall;
      r_rep   <= ((r_rep & ~w_clr_t) | w_fire) & w_act;
      r_ovf   <= w_coal | (r_ovf & ~clr_ovf);
      r_wp    <= r_wp + PW'(w_push);
      r_rp    <= r_rp + PW'(w_pop);
      r_cnt   <= r_cnt + CW'(w_push) - CW'(w_pop);
    end
  end
  always_ff @(posedge hz100) if (w_push) r_mem[r_wp] <= {w_kind, w_sel};
  assign btn_level  = r_lvl;
  assign fifo_count = r_cnt;
  assign ovf        = r_ovf;
  assign evt_valid  = r_cnt != '0;
  assign evt_data   = evt_valid ? r_mem[r_rp] : '0;
endmodule

// File: tb/tb_t03_pb_event_scanner.sv
// tb_t03_pb_event_scanner: table vectors, directed corner sequences and a randomized run,
// every cycle also compared against an event-level reference model.
module tb_t03_pb_event_scanner;
  localparam int N = 21, SYNC = 2, DEB = 4, DLY = 50, RATE = 10, DEPTH = 8, IDXW = 5;
  logic hz100 = 1'b0, reset = 1'b0, evt_ready = 1'b0, clr_ovf = 1'b0;
  logic [N-1:0] pb = '0, repeat_en = '0;
  logic [N-1:0] btn_level;
  logic evt_valid, ovf;
  logic [IDXW+1:0] evt_data;
  logic [3:0] fifo_count;
  int checks = 0, failures = 0;
  t03_pb_event_scanner dut (
    .hz100(hz100), .reset(reset), .pb(pb), .repeat_en(repeat_en), .evt_ready(evt_ready),
    .clr_ovf(clr_ovf), .btn_level(btn_level), .evt_valid(evt_valid), .evt_data(evt_data),
    .fifo_count(fifo_count), .ovf(ovf)
  );
  always #5 hz100 = ~hz100;
  logic [N-1:0] m_pipe [SYNC];
  logic [N-1:0] m_lvl, m_lvl_d;
  int m_run [N];
  int m_held [N];
  bit [2:0] m_pend [N];
  int m_q [$];
  bit m_ovf;
  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic m_clear();
    for (int k = 0; k < SYNC; k++) m_pipe[k] = '0;
    m_lvl = '0;
    m_lvl_d = '0;
    m_q.delete();
    m_ovf = 0;
    for (int i = 0; i < N; i++) begin
      m_run[i] = 0;
      m_held[i] = 0;
      m_pend[i] = 3'b000;
    end
  endtask
  // One clock edge of the reference: pending kinds per channel (0 press, 1 release, 2 repeat),
  // held time measured in cycles, event queue as a plain queue.
  task automatic m_step();
    logic [N-1:0] s, rise, fall, act, fire, nl;
    int sel, kind;
    bit coal, room;
    if (!reset) begin
      m_clear();
      return;
    end
    s = m_pipe[SYNC-1];
    rise = m_lvl & ~m_lvl_d;
    fall = ~m_lvl & m_lvl_d;
    act = m_lvl & repeat_en;
    nl = m_lvl;
    coal = 0;
    sel = -1;
    kind = 0;
    for (int i = 0; i < N; i++)
      fire[i] = act[i] && (m_held[i] + 1 >= DLY) && ((m_held[i] + 1 - DLY) % RATE == 0);
    for (int i = 0; i < N && sel < 0; i++)
      for (int k = 0; k < 3 && sel < 0; k++)
        if (m_pend[i][k]) begin
          sel = i;
          kind = k;
        end
    room = m_q.size() < DEPTH || evt_ready;
    if (m_q.size() > 0 && evt_ready) void'(m_q.pop_front());
    if (sel >= 0 && room) begin
      m_q.push_back(((kind + 1) << IDXW) | sel);
      m_pend[sel][kind] = 1'b0;
    end
    for (int i = 0; i < N; i++) begin
      if (rise[i]) begin coal |= m_pend[i][0]; m_pend[i][0] = 1'b1; end
      if (fall[i]) begin coal |= m_pend[i][1]; m_pend[i][1] = 1'b1; end
      if (fire[i]) begin coal |= m_pend[i][2]; m_pend[i][2] = 1'b1; end
      if (!act[i]) m_pend[i][2] = 1'b0;
      m_held[i] = act[i] ? m_held[i] + 1 : 0;
      if (s[i] == m_lvl[i]) m_run[i] = 0;
      else begin
        m_run[i]++;
        if (m_run[i] == DEB) begin
          nl[i] = ~m_lvl[i];
          m_run[i] = 0;
        end
      end
    end
    m_ovf = coal || (m_ovf && !clr_ovf);
    m_lvl_d = m_lvl;
    m_lvl = nl;
    for (int k = SYNC - 1; k > 0; k--) m_pipe[k] = m_pipe[k-1];
    m_pipe[0] = pb;
  endtask
  function automatic logic [63:0] m_vec();
    logic [6:0] h;
    h = m_q.size() > 0 ? 7'(m_q[0]) : 7'd0;
    return {30'd0, m_lvl, m_q.size() > 0, h, 4'(m_q.size()), m_ovf};
  endfunction
  task automatic step();
    @(posedge hz100);
    m_step();
    #1;
    chk("model", {30'd0, btn_level, evt_valid, evt_data, fifo_count, ovf}, m_vec());
  endtask
  function automatic logic [N-1:0] b(int x);
    return N'(1) << x;
  endfunction
  typedef struct {
    logic [N-1:0] pb, ren;
    logic rdy, clr;
    int n;
    logic [N-1:0] lvl;
    logic vld;
    logic [6:0] data;
    logic [3:0] cnt;
    logic ovf;
  } vec_t;
  function automatic vec_t mk(logic [N-1:0] p, logic [N-1:0] r, logic rd, logic c, int n,
                              logic [N-1:0] l, logic v, logic [6:0] d, logic [3:0] cn, logic o);
    vec_t t;
    t.pb = p; t.ren = r; t.rdy = rd; t.clr = c; t.n = n;
    t.lvl = l; t.vld = v; t.data = d; t.cnt = cn; t.ovf = o;
    return t;
  endfunction
  vec_t tv [$];
  int ev_t [$];
  logic [6:0] ev_d [$];
  int exp_t [7] = '{2, 51, 61, 71, 81, 91, 93};
  logic [6:0] exp_d4 [7] = '{7'h24, 7'h64, 7'h64, 7'h64, 7'h64, 7'h64, 7'h44};
  logic [6:0] exp_d5 [11] = '{7'h2A, 7'h2B, 7'h2C, 7'h2D, 7'h2E, 7'h2F, 7'h30, 7'h31, 7'h32, 7'h33, 7'h53};
  initial begin
    int t, rdy_pct;
    m_clear();
    tv.push_back(mk('0, '0, 0, 0, 2, '0, 0, 7'h00, 0, 0));
    tv.push_back(mk(b(7), '0, 0, 0, 5, '0, 0, 7'h00, 0, 0));
    tv.push_back(mk(b(7), '0, 0, 0, 1, b(7), 0, 7'h00, 0, 0));
    tv.push_back(mk(b(7), '0, 0, 0, 1, b(7), 0, 7'h00, 0, 0));
    tv.push_back(mk(b(7), '0, 0, 0, 1, b(7), 1, 7'h27, 1, 0));
    tv.push_back(mk(b(7), '0, 1, 0, 1, b(7), 0, 7'h00, 0, 0));
    tv.push_back(mk('0, '0, 0, 0, 5, b(7), 0, 7'h00, 0, 0));
    tv.push_back(mk('0, '0, 0, 0, 1, '0, 0, 7'h00, 0, 0));
    tv.push_back(mk('0, '0, 0, 0, 2, '0, 1, 7'h47, 1, 0));
    tv.push_back(mk(b(3), '0, 0, 0, 3, '0, 1, 7'h47, 1, 0));
    tv.push_back(mk('0, '0, 0, 0, 10, '0, 1, 7'h47, 1, 0));
    tv.push_back(mk('0, '0, 1, 0, 1, '0, 0, 7'h00, 0, 0));
    tv.push_back(mk(b(2) | b(9), '0, 0, 0, 6, b(2) | b(9), 0, 7'h00, 0, 0));
    tv.push_back(mk(b(2) | b(9), '0, 0, 0, 2, b(2) | b(9), 1, 7'h22, 1, 0));
    tv.push_back(mk(b(2) | b(9), '0, 0, 0, 1, b(2) | b(9), 1, 7'h22, 2, 0));
    tv.push_back(mk(b(2) | b(9), '0, 1, 0, 1, b(2) | b(9), 1, 7'h29, 1, 0));
    tv.push_back(mk(b(2) | b(9), '0, 1, 0, 1, b(2) | b(9), 0, 7'h00, 0, 0));
    tv.push_back(mk('0, '0, 1, 0, 10, '0, 0, 7'h00, 0, 0));
    repeat (3) step();
    chk("reset btn_level", btn_level, 0);
    chk("reset evt_valid", evt_valid, 0);
    chk("reset fifo_count", fifo_count, 0);
    reset = 1'b1;
    foreach (tv[j]) begin
      pb = tv[j].pb; repeat_en = tv[j].ren; evt_ready = tv[j].rdy; clr_ovf = tv[j].clr;
      repeat (tv[j].n) step();
      chk($sformatf("tv%0d btn_level", j), btn_level, tv[j].lvl);
      chk($sformatf("tv%0d evt_valid", j), evt_valid, tv[j].vld);
      chk($sformatf("tv%0d evt_data", j), evt_data, tv[j].data);
      chk($sformatf("tv%0d fifo_count", j), fifo_count, tv[j].cnt);
      chk($sformatf("tv%0d ovf", j), ovf, tv[j].ovf);
    end
    // Auto-repeat on channel 4: press, five repeats, release.
    repeat_en = b(4); evt_ready = 1'b1; pb = b(4);
    t = 0;
    while (!btn_level[4] && t < 20) begin step(); t++; end
    chk("repeat debounce latency", t, SYNC + DEB);
    for (int t2 = 1; t2 <= 110; t2++) begin
      step();
      if (evt_valid) begin ev_t.push_back(t2); ev_d.push_back(evt_data); end
      if (t2 == 85) pb = '0;
    end
    chk("repeat event count", ev_t.size(), 7);
    for (int i = 0; i < 7 && i < ev_t.size(); i++) begin
      chk($sformatf("repeat ev%0d time", i), ev_t[i], exp_t[i]);
      chk($sformatf("repeat ev%0d data", i), ev_d[i], exp_d4[i]);
    end
    repeat_en = '0;
    // Full FIFO with pending events, then a coalesced press.
    evt_ready = 1'b0; pb = N'(21'h0FFC00);
    repeat (16) step();
    chk("full fifo_count", fifo_count, 8);
    chk("full head", evt_data, 7'h2A);
    chk("full ovf clear", ovf, 0);
    pb[19] = 1'b0;
    repeat (8) step();
    chk("release pending no ovf", ovf, 0);
    pb[19] = 1'b1;
    repeat (8) step();
    chk("coalesce ovf", ovf, 1);
    chk("coalesce fifo_count", fifo_count, 8);
    evt_ready = 1'b1; ev_d.delete();
    for (int t2 = 0; t2 < 20; t2++) begin
      if (evt_valid) ev_d.push_back(evt_data);
      step();
    end
    chk("drain count", ev_d.size(), 11);
    for (int i = 0; i < 11 && i < ev_d.size(); i++) chk($sformatf("drain ev%0d", i), ev_d[i], exp_d5[i]);
    chk("drain empty", fifo_count, 0);
    chk("ovf sticky", ovf, 1);
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    chk("clr_ovf", ovf, 0);
    pb = '0;
    repeat (20) step();
    chk("release drain", fifo_count, 0);
    // Asynchronous reset with a partly filled FIFO and events still pending.
    evt_ready = 1'b0; pb = N'(21'h0003FF);
    t = 0;
    while (fifo_count != 5 && t < 30) begin step(); t++; end
    chk("fill to five", fifo_count, 5);
    #2 reset = 1'b0;
    m_clear();
    #1;
    chk("async reset btn_level", btn_level, 0);
    chk("async reset evt_valid", evt_valid, 0);
    chk("async reset evt_data", evt_data, 0);
    chk("async reset fifo_count", fifo_count, 0);
    chk("async reset ovf", ovf, 0);
    repeat (2) step();
    reset = 1'b1;
    for (int t2 = 1; t2 <= 7; t2++) begin
      step();
      chk($sformatf("post-reset quiet %0d", t2), evt_valid, 0);
    end
    step();
    chk("post-reset first valid", evt_valid, 1);
    chk("post-reset first event", evt_data, 7'h20);
    pb = '0; evt_ready = 1'b1;
    repeat (30) step();
    chk("post-reset drain", fifo_count, 0);
    // Randomized traffic checked cycle by cycle against the model.
    repeat_en = N'($urandom());
    rdy_pct = 50;
    for (int c = 0; c < 4000; c++) begin
      if (c % 250 == 0) rdy_pct = $urandom_range(10, 100);
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 59) == 0) pb[i] = ~pb[i];
        if ($urandom_range(0, 799) == 0) repeat_en[i] = ~repeat_en[i];
      end
      evt_ready = $urandom_range(1, 100) <= rdy_pct;
      clr_ovf = $urandom_range(0, 63) == 0;
      if (c == 2000) begin
        reset = 1'b0;
        m_clear();
        repeat (2) step();
        reset = 1'b1;
      end
      step();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
